mult32x64_lut6_akak: RTL and testbench

Unsigned 32×64-bit multiplier that produces its 96-bit product in carry-save form: two vectors whose sum modulo 2^96 is the product. It is the partial-product and reduction stage of the wide multiplier datapath. A downstream adder or further 4:2 compression resolves the final product. Partial products use radix-4 digits, which map onto LUT6 primitives, and are reduced by a tree of 4:2 compressors. The two result vectors are registered.

---
 rtl/mult_pkg.sv | 15 +
 rtl/compressor_4to2.sv | 39 +++
 rtl/mult32x64_lut6_akak.sv | 93 +++++++++
 tb/tb_mult32x64_lut6_akak.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths and helpers for the wide multiplier datapath.
// Operand widths are fixed; IN0_W must stay even for radix-4 digit recoding.
package mult_pkg;

    localparam int unsigned IN0_W  = 32;
    localparam int unsigned IN1_W  = 64;
    localparam int unsigned OUT_W  = IN0_W + IN1_W;
    localparam int unsigned NUM_PP = IN0_W / 2;
    localparam int unsigned PP_W   = IN1_W + 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/compressor_4to2.sv
// 4:2 carry-save compressor built from two cascaded 3:2 stages.
// Guarantees s_o + cy_o == a_i + b_i + c_i + d_i (mod 2^W); carries past bit W-1 are dropped.
module compressor_4to2
    import mult_pkg::*;
#(
    parameter int unsigned W = 96
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] cy_o
);

    logic [W-1:0] s1;
    logic [W-1:0] c1;
    logic [W-2:0] m1;
    logic [W-2:0] m2;

    for (genvar i = 0; i < W; i++) begin : g_s1
        assign s1[i] = a_i[i] ^ b_i[i] ^ c_i[i];
    end

    // Majority of the top bit would shift out of the word, so it is never formed.
    for (genvar i = 0; i < W - 1; i++) begin : g_m1
        assign m1[i] = maj3(a_i[i], b_i[i], c_i[i]);
    end

    assign c1 = {m1, 1'b0};
    assign s_o = s1 ^ c1 ^ d_i;

    for (genvar i = 0; i < W - 1; i++) begin : g_m2
        assign m2[i] = maj3(s1[i], c1[i], d_i[i]);
    end

    assign cy_o = {m2, 1'b0};

endmodule

// File: rtl/mult32x64_lut6_akak.sv
// Unsigned 32x64 multiplier: radix-4 partial products reduced by a 4:2 compressor tree,
// with the final carry-save pair registered (one-cycle latency, one product per cycle).
module mult32x64_lut6_akak
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN0_W-1:0] in0,
    input  logic [IN1_W-1:0] in1,
    output logic [OUT_W-1:0] out0,
    output logic [OUT_W-1:0] out1
);

    logic [OUT_W-1:0] pp_ext [NUM_PP];
    logic [OUT_W-1:0] l1     [8];
    logic [OUT_W-1:0] l2     [4];
    logic [OUT_W-1:0] sum_d;
    logic [OUT_W-1:0] carry_d;
    logic [OUT_W-1:0] out0_q;
    logic [OUT_W-1:0] out1_q;

    // Each pp bit depends only on the digit and two adjacent multiplicand bits (plus the x3 add),
    // which fits one LUT6 per bit.
    for (genvar k = 0; k < NUM_PP; k++) begin : g_pp
        logic [1:0]      digit;
        logic [PP_W-1:0] pp;

        assign digit = in0[2*k+1 -: 2];

        always_comb begin
            pp = '0;
            unique case (digit)
                2'd0: pp = '0;
                2'd1: pp = {2'b00, in1};
                2'd2: pp = {1'b0, in1, 1'b0};
                2'd3: pp = {2'b00, in1} + {1'b0, in1, 1'b0};
            endcase
        end

        assign pp_ext[k] = {{(OUT_W - PP_W){1'b0}}, pp} << (2 * k);
    end

    for (genvar g = 0; g < 4; g++) begin : g_l1
        compressor_4to2 #(
            .W(OUT_W)
        ) u_cmp (
            .a_i (pp_ext[4*g]),
            .b_i (pp_ext[4*g+1]),
            .c_i (pp_ext[4*g+2]),
            .d_i (pp_ext[4*g+3]),
            .s_o (l1[2*g]),
            .cy_o(l1[2*g+1])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_l2
        compressor_4to2 #(
            .W(OUT_W)
        ) u_cmp (
            .a_i (l1[4*g]),
            .b_i (l1[4*g+1]),
            .c_i (l1[4*g+2]),
            .d_i (l1[4*g+3]),
            .s_o (l2[2*g]),
            .cy_o(l2[2*g+1])
        );
    end

    compressor_4to2 #(
        .W(OUT_W)
    ) u_l3 (
        .a_i (l2[0]),
        .b_i (l2[1]),
        .c_i (l2[2]),
        .d_i (l2[3]),
        .s_o (sum_d),
        .cy_o(carry_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            out0_q <= sum_d;
            out1_q <= carry_d;
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;

endmodule

// File: tb/tb_mult32x64_lut6_akak.sv
// Directed and random checks of the carry-save multiplier and of the 4:2 compressor alone.
module tb_mult32x64_lut6_akak;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in0;
    logic [63:0] in1;
    logic [95:0] out0;
    logic [95:0] out1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult32x64_lut6_akak dut (
        .clk (clk),
        .rst (rst),
        .in0 (in0),
        .in1 (in1),
        .out0(out0),
        .out1(out1)
    );

    logic [7:0] ca, cb, cc, cd, cs, ccy;
    compressor_4to2 #(
        .W(8)
    ) u_c8 (
        .a_i (ca),
        .b_i (cb),
        .c_i (cc),
        .d_i (cd),
        .s_o (cs),
        .cy_o(ccy)
    );

    logic [127:0] wa, wb, wc, wd, ws, wcy;
    compressor_4to2 #(
        .W(128)
    ) u_c128 (
        .a_i (wa),
        .b_i (wb),
        .c_i (wc),
        .d_i (wd),
        .s_o (ws),
        .cy_o(wcy)
    );

    task automatic check96(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive operands away from the edge, then sample just after the capturing edge.
    task automatic apply(input logic r, input logic [31:0] a, input logic [63:0] b);
        @(negedge clk);
        rst = r;
        in0 = a;
        in1 = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] model(input logic [31:0] a, input logic [63:0] b);
        logic [95:0] wa96;
        logic [95:0] wb96;
        wa96 = {64'd0, a};
        wb96 = {32'd0, b};
        return wa96 * wb96;
    endfunction

    initial begin
        logic [7:0]   e8, o8;
        logic [127:0] e128, o128;
        logic [31:0]  ra;
        logic [63:0]  rb;

        rst = 1'b1;
        in0 = '0;
        in1 = '0;

        // Standalone compressor, W=8: sweep a exhaustively with random companions.
        for (int i = 0; i < 256; i++) begin
            ca = i[7:0];
            cb = 8'($urandom);
            cc = 8'($urandom);
            cd = 8'($urandom);
            #1;
            e8 = 8'(ca + cb + cc + cd);
            o8 = 8'(cs + ccy);
            checks++;
            assert (o8 === e8) else begin
                errors++;
                $error("FAIL cmp8 a=%h: observed %h expected %h", ca, o8, e8);
            end
        end
        ca = 8'hFF; cb = 8'hFF; cc = 8'hFF; cd = 8'hFF;
        #1;
        o8 = 8'(cs + ccy);
        checks++;
        assert (o8 === 8'hFC) else begin
            errors++;
            $error("FAIL cmp8_ones: observed %h expected fc", o8);
        end

        // Standalone compressor, W=128.
        for (int i = 0; i < 200; i++) begin
            wa = {$urandom, $urandom, $urandom, $urandom};
            wb = {$urandom, $urandom, $urandom, $urandom};
            wc = {$urandom, $urandom, $urandom, $urandom};
            wd = {$urandom, $urandom, $urandom, $urandom};
            #1;
            e128 = wa + wb + wc + wd;
            o128 = ws + wcy;
            check128("cmp128_rand", o128, e128);
        end

        // Reset state.
        apply(1'b1, 32'h0, 64'h0);
        apply(1'b1, 32'h0, 64'h0);
        check96("rst_out0", out0, 96'h0);
        check96("rst_out1", out1, 96'h0);

        apply(1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        check96("zero_sum", out0 + out1, 96'h0);
        check96("zero_out0", out0, 96'h0);
        check96("zero_out1", out1, 96'h0);

        apply(1'b0, 32'h1, 64'h0123_4567_89AB_CDEF);
        check96("one_times", out0 + out1, 96'h0000_0000_0123_4567_89AB_CDEF);

        apply(1'b0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check96("all_ones", out0 + out1, 96'hFFFF_FFFE_FFFF_FFFF_0000_0001);

        apply(1'b0, 32'h2, 64'h8000_0000_0000_0000);
        check96("bit64_carry", out0 + out1, 96'h1_0000_0000_0000_0000);

        apply(1'b0, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        check96("top_digit", out0 + out1, 96'h7FFF_FFFF_FFFF_FFFF_8000_0000);

        apply(1'b0, 32'h3, 64'h5555_5555_5555_5555);
        check96("digit3", out0 + out1, 96'h0000_0000_FFFF_FFFF_FFFF_FFFF);

        // Reset held with live operands must keep both vectors cleared.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
            check96("rst_hold_out0", out0, 96'h0);
            check96("rst_hold_out1", out1, 96'h0);
        end
        apply(1'b0, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
        check96("rst_release", out0 + out1, 96'hDEAD_BEEE_FFFF_FFFF_2152_4111);

        // Back-to-back random operands, one per cycle.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = {$urandom, $urandom};
            apply(1'b0, ra, rb);
            check96("random", out0 + out1, model(ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
